// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared widths, address slices and FSM states for the L1 D-cache
//            controller.
// Revision : 1.0
// ============================================================================
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int TAG_W      = 23;
  localparam int IDX_W      = 4;
  localparam int LINE_W     = 256;
  localparam int WORD_W     = 32;
  localparam int WORDS      = LINE_W / WORD_W;
  localparam int SEL_W      = 3;
  localparam int OFF_W      = 5;
  localparam int SRAM_TAG_W = TAG_W + 2;

  localparam int VALID_BIT  = 24;
  localparam int DIRTY_BIT  = 23;
  localparam int TAG_LSB    = 9;
  localparam int IDX_LSB    = 5;
  localparam int SEL_LSB    = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITEBACK  = 2'd1,
    READMISS   = 2'd2,
    READMISSOK = 2'd3
  } state_e;

  function automatic logic [SRAM_TAG_W-1:0] make_tag(input logic valid,
                                                     input logic dirty,
                                                     input logic [TAG_W-1:0] tag);
    return {valid, dirty, tag};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_if
// Purpose  : CPU, backing-memory and tag/data-storage signals of the D-cache
//            controller; master = controller side, slave = environment side.
// Revision : 1.0
// ============================================================================
interface dcache_if;
  import dcache_pkg::*;

  logic [ADDR_W-1:0]     cpu_addr_i;
  logic [WORD_W-1:0]     cpu_data_i;
  logic                  cpu_MemRead_i;
  logic                  cpu_MemWrite_i;
  logic [WORD_W-1:0]     cpu_data_o;
  logic                  cpu_stall_o;

  logic [ADDR_W-1:0]     mem_addr_o;
  logic [LINE_W-1:0]     mem_data_o;
  logic                  mem_enable_o;
  logic                  mem_write_o;
  logic [LINE_W-1:0]     mem_data_i;
  logic                  mem_ack_i;

  logic [IDX_W-1:0]      sram_addr_o;
  logic [SRAM_TAG_W-1:0] sram_tag_o;
  logic [LINE_W-1:0]     sram_data_o;
  logic                  sram_enable_o;
  logic                  sram_write_o;
  logic [SRAM_TAG_W-1:0] sram_tag_i;
  logic [LINE_W-1:0]     sram_data_i;
  logic                  sram_hit_i;

  modport master (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
           mem_data_i, mem_ack_i, sram_tag_i, sram_data_i, sram_hit_i,
    output cpu_data_o, cpu_stall_o, mem_addr_o, mem_data_o, mem_enable_o,
           mem_write_o, sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o,
           sram_write_o
  );

  modport slave (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
           mem_data_i, mem_ack_i, sram_tag_i, sram_data_i, sram_hit_i,
    input  cpu_data_o, cpu_stall_o, mem_addr_o, mem_data_o, mem_enable_o,
           mem_write_o, sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o,
           sram_write_o
  );

endinterface
`default_nettype wire

// File: rtl/dcache_word_merge.sv
`default_nettype none
// ============================================================================
// Module   : dcache_word_merge
// Purpose  : Selects one 32-bit word of a line and builds the line with that
//            word replaced; shared by load and store paths.
// Revision : 1.0
// ============================================================================
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic [LINE_W-1:0] line_o
);

  logic [WORD_W-1:0] w_words [WORDS];

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign w_words[gi] = line_i[gi*WORD_W +: WORD_W];
    assign line_o[gi*WORD_W +: WORD_W] = (sel_i == SEL_W'(gi)) ? wdata_i : w_words[gi];
  end

  assign rdata_o = w_words[sel_i];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : 2-way L1 D-cache controller: lookup, store merge, dirty-victim
//            write-back and line refill. DCACHE_PERF_CNT_EN adds hit/miss counters.
// Revision : 1.0
// ============================================================================
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  dcache_if.master  bus_io
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  victim_tag_q, victim_tag_d;
  logic [LINE_W-1:0] victim_line_q, victim_line_d;
  logic [LINE_W-1:0] refill_q, refill_d;

  logic              w_req;
  logic              w_store;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [SEL_W-1:0]  w_sel;
  logic [WORD_W-1:0] w_rd_word;
  logic [LINE_W-1:0] w_merged;

  assign w_req   = bus_io.cpu_MemRead_i | bus_io.cpu_MemWrite_i;
  assign w_store = bus_io.cpu_MemWrite_i;
  assign w_tag   = bus_io.cpu_addr_i[ADDR_W-1:TAG_LSB];
  assign w_idx   = bus_io.cpu_addr_i[TAG_LSB-1:IDX_LSB];
  assign w_sel   = bus_io.cpu_addr_i[IDX_LSB-1:SEL_LSB];

  dcache_word_merge u_merge (
    .line_i  (bus_io.sram_data_i),
    .sel_i   (w_sel),
    .wdata_i (bus_io.cpu_data_i),
    .rdata_o (w_rd_word),
    .line_o  (w_merged)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      victim_tag_q  <= '0;
      victim_line_q <= '0;
      refill_q      <= '0;
    end else begin
      state_q       <= state_d;
      victim_tag_q  <= victim_tag_d;
      victim_line_q <= victim_line_d;
      refill_q      <= refill_d;
    end
  end

  // Outputs are forced idle while reset is held so an aborted miss drives nothing.
  always_comb begin
    state_d              = state_q;
    victim_tag_d         = victim_tag_q;
    victim_line_d        = victim_line_q;
    refill_d             = refill_q;
    bus_io.cpu_data_o    = '0;
    bus_io.cpu_stall_o   = 1'b0;
    bus_io.mem_addr_o    = '0;
    bus_io.mem_data_o    = '0;
    bus_io.mem_enable_o  = 1'b0;
    bus_io.mem_write_o   = 1'b0;
    bus_io.sram_addr_o   = w_idx;
    bus_io.sram_tag_o    = make_tag(1'b0, 1'b0, w_tag);
    bus_io.sram_data_o   = '0;
    bus_io.sram_enable_o = 1'b0;
    bus_io.sram_write_o  = 1'b0;
    if (!rst_i) begin
      bus_io.sram_enable_o = w_req;
      case (state_q)
        IDLE: begin
          if (w_req && bus_io.sram_hit_i) begin
            if (w_store) begin
              bus_io.sram_write_o = 1'b1;
              bus_io.sram_data_o  = w_merged;
              bus_io.sram_tag_o   = make_tag(1'b1, 1'b1, w_tag);
            end else begin
              bus_io.cpu_data_o = w_rd_word;
            end
          end else if (w_req) begin
            bus_io.cpu_stall_o = 1'b1;
            victim_tag_d       = bus_io.sram_tag_i[TAG_W-1:0];
            victim_line_d      = bus_io.sram_data_i;
            state_d = (bus_io.sram_tag_i[VALID_BIT] && bus_io.sram_tag_i[DIRTY_BIT])
                      ? WRITEBACK : READMISS;
          end
        end
        WRITEBACK: begin
          bus_io.cpu_stall_o  = 1'b1;
          bus_io.mem_enable_o = 1'b1;
          bus_io.mem_write_o  = 1'b1;
          bus_io.mem_addr_o   = {victim_tag_q, w_idx, OFF_W'(0)};
          bus_io.mem_data_o   = victim_line_q;
          if (bus_io.mem_ack_i) state_d = READMISS;
        end
        READMISS: begin
          bus_io.cpu_stall_o  = 1'b1;
          bus_io.mem_enable_o = 1'b1;
          bus_io.mem_addr_o   = {bus_io.cpu_addr_i[ADDR_W-1:IDX_LSB], OFF_W'(0)};
          if (bus_io.mem_ack_i) begin
            refill_d = bus_io.mem_data_i;
            state_d  = READMISSOK;
          end
        end
        READMISSOK: begin
          bus_io.cpu_stall_o  = 1'b1;
          bus_io.sram_write_o = 1'b1;
          bus_io.sram_data_o  = refill_q;
          bus_io.sram_tag_o   = make_tag(1'b1, 1'b0, w_tag);
          state_d             = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic        retry_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        w_lookup_hit;
  logic        w_lookup_miss;

  assign w_lookup_hit  = (state_q == IDLE) && w_req &&  bus_io.sram_hit_i;
  assign w_lookup_miss = (state_q == IDLE) && w_req && !bus_io.sram_hit_i;

  // retry_q marks the post-refill lookup so it is not counted as a hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (w_lookup_hit) begin
        retry_q <= 1'b0;
        if (!retry_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (w_lookup_miss) begin
        retry_q    <= 1'b1;
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Purpose  : Directed bench for dcache_ctrl with storage and memory models.
// Revision : 1.0
// ============================================================================
module tb_dcache_ctrl;

  localparam int LAT = 3;

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;

  txn_t        mem_q [$];
  logic [31:0] rd_q  [$];
  logic [255:0] mem_line [bit [31:0]];
  logic [31:0]  gold     [bit [31:0]];

  logic [24:0]  stag [0:1][0:15];
  logic [255:0] sdat [0:1][0:15];
  logic         lru  [0:15];
  logic         m_h0, m_h1, m_way;
  logic [3:0]   m_idx;

  dcache_if ifc ();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (ifc)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-way storage model: presents the hit way, else the LRU victim.
  always_comb begin
    m_idx = ifc.cpu_addr_i[8:5];
    m_h0  = stag[0][m_idx][24] && (stag[0][m_idx][22:0] == ifc.cpu_addr_i[31:9]);
    m_h1  = stag[1][m_idx][24] && (stag[1][m_idx][22:0] == ifc.cpu_addr_i[31:9]);
    m_way = m_h0 ? 1'b0 : (m_h1 ? 1'b1 : lru[m_idx]);
    ifc.sram_hit_i  = ifc.sram_enable_o && (m_h0 || m_h1);
    ifc.sram_tag_i  = stag[m_way][m_idx];
    ifc.sram_data_i = sdat[m_way][m_idx];
  end

  always @(posedge clk) begin
    if (ifc.sram_enable_o && (ifc.sram_write_o || m_h0 || m_h1)) begin
      if (ifc.sram_write_o) begin
        stag[m_way][ifc.sram_addr_o] <= ifc.sram_tag_o;
        sdat[m_way][ifc.sram_addr_o] <= ifc.sram_data_o;
      end
      lru[m_idx] <= ~m_way;
    end
  end

  function automatic logic [31:0] init_word(input logic [31:0] ba);
    if (ba == 32'h0000_0404) return 32'hDEADBEEF;
    return {ba[15:0] ^ 16'h5A5A, ba[15:0]};
  endfunction

  function automatic logic [255:0] mline(input logic [31:0] la);
    logic [255:0] l;
    if (mem_line.exists(la)) return mem_line[la];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = init_word(la + 32'(4*k));
    return l;
  endfunction

  function automatic logic [31:0] gword(input logic [31:0] ba);
    logic [31:0] wa;
    wa = {ba[31:2], 2'b00};
    if (gold.exists(wa)) return gold[wa];
    return init_word(wa);
  endfunction

  function automatic logic [255:0] gline(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = gword({a[31:5], 5'b0} + 32'(4*k));
    return l;
  endfunction

  task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic push_txn(input logic [31:0] a, input logic wr, input logic [255:0] d);
    txn_t t;
    t.addr = a; t.wr = wr; t.data = d;
    mem_q.push_back(t);
  endtask

  task automatic serve_mem(input string nm);
    txn_t t;
    logic [31:0] la;
    logic wr;
    logic [255:0] rdata;
    la = ifc.mem_addr_o;
    wr = ifc.mem_write_o;
    tests++;
    assert (mem_q.size() != 0) else begin
      fails++;
      $error("FAIL %s_mem_txn: observed request %h expected none", nm, la);
    end
    if (mem_q.size() != 0) begin
      t = mem_q.pop_front();
      chk({nm, "_mem_addr"}, 256'(la), 256'(t.addr));
      chk({nm, "_mem_write"}, 256'(wr), 256'(t.wr));
      if (t.wr) chk({nm, "_wb_data"}, ifc.mem_data_o, t.data);
    end
    if (wr) mem_line[la] = ifc.mem_data_o;
    rdata = mline(la);
    repeat (LAT - 1) @(negedge clk);
    ifc.mem_data_i = wr ? '0 : rdata;
    ifc.mem_ack_i  = 1'b1;
    @(negedge clk);
    ifc.mem_ack_i  = 1'b0;
    ifc.mem_data_i = '0;
    if (!wr) begin
      #1;
      chk({nm, "_en_drop"}, 256'(ifc.mem_enable_o), 256'(0));
    end
  endtask

  // kind: 0 = hit, 1 = clean miss, 2 = dirty miss
  task automatic access(input logic [31:0] a, input logic [31:0] d, input bit st,
                        input bit both, input int kind, input string nm);
    int c0;
    int n;
    int exp_cyc;
    ifc.cpu_addr_i     = a;
    ifc.cpu_data_i     = d;
    ifc.cpu_MemWrite_i = st;
    ifc.cpu_MemRead_i  = !st || both;
    if (st) gold[{a[31:2], 2'b00}] = d;
    else rd_q.push_back(gword(a));
    exp_cyc = (kind == 0) ? 0 : ((kind == 1) ? LAT + 2 : 2 * LAT + 2);
    if (kind == 0) exp_hits++; else exp_misses++;
    c0 = cyc;
    n  = 0;
    #1;
    while (ifc.cpu_stall_o && n < 50) begin
      if (ifc.mem_enable_o) serve_mem(nm);
      else @(negedge clk);
      #1;
      n++;
    end
    chk({nm, "_stall_end"}, 256'(ifc.cpu_stall_o), 256'(0));
    chk({nm, "_stall_cyc"}, 256'(cyc - c0), 256'(exp_cyc));
    if (st) begin
      chk({nm, "_sram_wr"}, 256'(ifc.sram_write_o), 256'(1));
      chk({nm, "_sram_tag"}, 256'(ifc.sram_tag_o), 256'({2'b11, a[31:9]}));
      chk({nm, "_sram_line"}, ifc.sram_data_o, gline(a));
    end else begin
      chk({nm, "_ld_data"}, 256'(ifc.cpu_data_o), 256'(rd_q.pop_front()));
    end
    @(negedge clk);
    ifc.cpu_MemRead_i  = 1'b0;
    ifc.cpu_MemWrite_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 16; s++) begin
        stag[w][s] = '0;
        sdat[w][s] = '0;
      end
    for (int s = 0; s < 16; s++) lru[s] = 1'b0;
    ifc.cpu_addr_i     = 32'h0000_0404;
    ifc.cpu_data_i     = '0;
    ifc.cpu_MemRead_i  = 1'b1;
    ifc.cpu_MemWrite_i = 1'b0;
    ifc.mem_data_i     = '0;
    ifc.mem_ack_i      = 1'b0;

    // Reset with a request pending: every output held at zero.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 256'(ifc.cpu_stall_o), 256'(0));
    chk("rst_mem_en", 256'(ifc.mem_enable_o), 256'(0));
    chk("rst_mem_wr", 256'(ifc.mem_write_o), 256'(0));
    chk("rst_sram_en", 256'(ifc.sram_enable_o), 256'(0));
    chk("rst_sram_wr", 256'(ifc.sram_write_o), 256'(0));
    chk("rst_mem_addr", 256'(ifc.mem_addr_o), 256'(0));
    chk("rst_mem_data", ifc.mem_data_o, 256'(0));
    chk("rst_cpu_data", 256'(ifc.cpu_data_o), 256'(0));
`ifdef DCACHE_PERF_CNT_EN
    chk("rst_hit_cnt", 256'(hit_cnt), 256'(0));
    chk("rst_miss_cnt", 256'(miss_cnt), 256'(0));
`endif
    rst = 1'b0;
    ifc.cpu_MemRead_i = 1'b0;
    @(negedge clk);

    push_txn(32'h400, 1'b0, '0);
    access(32'h404, 32'h0, 1'b0, 1'b0, 1, "cold_ld");
    access(32'h404, 32'h1234_5678, 1'b1, 1'b0, 0, "st_hit");
    access(32'h404, 32'h0, 1'b0, 1'b0, 0, "ld_hit");

    push_txn(32'h000, 1'b0, '0);
    access(32'h000, 32'hAAAA_0000, 1'b1, 1'b0, 1, "st_miss0");
    push_txn(32'h400, 1'b1, gline(32'h400));
    push_txn(32'h200, 1'b0, '0);
    access(32'h200, 32'hBBBB_0200, 1'b1, 1'b0, 2, "st_miss200");
    push_txn(32'h000, 1'b1, gline(32'h000));
    push_txn(32'h400, 1'b0, '0);
    access(32'h400, 32'h0, 1'b0, 1'b0, 2, "ld_wb400");

    push_txn(32'h200, 1'b1, gline(32'h200));
    push_txn(32'h800, 1'b0, '0);
    access(32'h808, 32'hCAFE_F00D, 1'b1, 1'b0, 2, "st_miss808");
    access(32'h808, 32'h0, 1'b0, 1'b0, 0, "ld808");
    access(32'h800, 32'h0, 1'b0, 1'b0, 0, "ld800");
    access(32'h81C, 32'h0, 1'b0, 1'b0, 0, "ld81c");
    access(32'h80C, 32'h0BAD_CAFE, 1'b1, 1'b1, 0, "st_both");
    access(32'h80C, 32'h0, 1'b0, 1'b0, 0, "ld80c");

    // Reset in the middle of a refill, then a stray ack.
    ifc.cpu_addr_i    = 32'h1000;
    ifc.cpu_MemRead_i = 1'b1;
    #1;
    chk("abort_miss_stall", 256'(ifc.cpu_stall_o), 256'(1));
    @(negedge clk);
    #1;
    chk("abort_rm_en", 256'(ifc.mem_enable_o), 256'(1));
    chk("abort_rm_addr", 256'(ifc.mem_addr_o), 256'(32'h1000));
    rst = 1'b1;
    #1;
    chk("abort_rst_stall", 256'(ifc.cpu_stall_o), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    ifc.cpu_MemRead_i = 1'b0;
    #1;
    chk("abort_idle_stall", 256'(ifc.cpu_stall_o), 256'(0));
    chk("abort_idle_en", 256'(ifc.mem_enable_o), 256'(0));
    ifc.mem_ack_i  = 1'b1;
    ifc.mem_data_i = '1;
    #1;
    chk("late_ack_sram_wr", 256'(ifc.sram_write_o), 256'(0));
    @(negedge clk);
    ifc.mem_ack_i  = 1'b0;
    ifc.mem_data_i = '0;
    #1;
    chk("late_ack_stall", 256'(ifc.cpu_stall_o), 256'(0));
    chk("late_ack_en", 256'(ifc.mem_enable_o), 256'(0));
`ifdef DCACHE_PERF_CNT_EN
    chk("abort_miss_cnt", 256'(miss_cnt), 256'(0));
`endif
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clk);

    access(32'h808, 32'h0, 1'b0, 1'b0, 0, "p_ld808");
    access(32'h400, 32'h0, 1'b0, 1'b0, 0, "p_ld400");
    access(32'h80C, 32'h0, 1'b0, 1'b0, 0, "p_ld80c");
    push_txn(32'h1000, 1'b0, '0);
    access(32'h1000, 32'h0, 1'b0, 1'b0, 1, "p_ld1000");
    push_txn(32'h800, 1'b1, gline(32'h800));
    push_txn(32'h2000, 1'b0, '0);
    access(32'h2000, 32'h0, 1'b0, 1'b0, 2, "p_ld2000");
`ifdef DCACHE_PERF_CNT_EN
    chk("perf_hits", 256'(hit_cnt), 256'(exp_hits));
    chk("perf_misses", 256'(miss_cnt), 256'(exp_misses));
`endif
    chk("mem_q_drained", 256'(mem_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
